// File: rtl/fetch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_pkg
// Shared CPU-front-end definitions used by the fetch controller and its queue:
//   NOP_INST      - canonical no-op (addi x0,x0,0) shown when nothing is valid
//   RESET_PC_DEF  - default byte PC fetched first after reset
//   IMEM_AW_DEF   - default instruction-memory word-address width
//   fq_entry_t    - one fetch-queue slot {pc, word}
//   fq_op_e       - per-cycle queue operation decoded from push/pop
// -----------------------------------------------------------------------------
package fetch_ctrl_pkg;

    localparam logic [31:0] NOP_INST     = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int          IMEM_AW_DEF  = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } fq_entry_t;

    typedef enum logic [1:0] {
        FQ_IDLE     = 2'b00,
        FQ_PUSH     = 2'b01,
        FQ_POP      = 2'b10,
        FQ_PUSH_POP = 2'b11
    } fq_op_e;

    function automatic fq_op_e fq_decode(input logic push, input logic pop);
        fq_op_e op;
        unique case ({pop, push})
            2'b01:   op = FQ_PUSH;
            2'b10:   op = FQ_POP;
            2'b11:   op = FQ_PUSH_POP;
            default: op = FQ_IDLE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/fetch_ctrl_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Two-entry in-order queue of fetched {pc, word} pairs.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset (empties the queue)
//   i_push       - write i_entry at the tail (accepted if not full or popping)
//   i_entry      - entry to push
//   i_pop        - remove the head (ignored when empty)
//   i_flush      - empty the queue; overrides any same-cycle push/pop
//   o_head       - head entry (meaningful only when o_valid)
//   o_valid      - queue holds at least one entry
//   o_count      - occupancy, 0..2
// -----------------------------------------------------------------------------
module fetch_queue
    import fetch_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_push,
    input  fq_entry_t  i_entry,
    input  logic       i_pop,
    input  logic       i_flush,
    output fq_entry_t  o_head,
    output logic       o_valid,
    output logic [1:0] o_count
);

    logic [1:0] r_count;
    fq_entry_t  r_ent0;    // head
    fq_entry_t  r_ent1;    // tail when two entries are held
    logic       w_pop_ok;
    logic       w_push_ok;
    fq_op_e     w_op;

    // Guard both operations locally so occupancy can never leave 0..2,
    // whatever the requester does.
    assign w_pop_ok  = i_pop && (r_count != 2'd0);
    assign w_push_ok = i_push && ((r_count != 2'd2) || w_pop_ok);
    assign w_op      = fq_decode(w_push_ok, w_pop_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_ent0  <= '0;
            r_ent1  <= '0;
        end else if (i_flush) begin
            r_count <= '0;
        end else begin
            unique case (w_op)
                FQ_PUSH: begin
                    if (r_count == 2'd0) begin
                        r_ent0 <= i_entry;
                    end else begin
                        r_ent1 <= i_entry;
                    end
                    r_count <= r_count + 2'd1;
                end
                FQ_POP: begin
                    r_ent0  <= r_ent1;
                    r_count <= r_count - 2'd1;
                end
                FQ_PUSH_POP: begin
                    // Occupancy unchanged; the new entry lands behind
                    // whatever survives the pop.
                    if (r_count == 2'd1) begin
                        r_ent0 <= i_entry;
                    end else begin
                        r_ent0 <= r_ent1;
                        r_ent1 <= i_entry;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_head  = r_ent0;
    assign o_valid = (r_count != 2'd0);
    assign o_count = r_count;

endmodule

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
// Instruction fetch front end: holds the fetch PC, reads a combinational
// instruction ROM and buffers up to two fetched instructions for decode.
// Parameters:
//   IMEM_AW  - instruction-memory word-address width
//   RESET_PC - byte PC fetched first after reset
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   imem_addr   - word address to the ROM (fpc[IMEM_AW+1:2], wraps)
//   imem_data   - ROM word for imem_addr, same cycle
//   redirect    - taken branch/jump: flush queue, reload fpc
//   redirect_pc - byte target for redirect (low two bits dropped)
//   halt        - level; suppresses new fetches, queue still drains
//   inst_valid  - head instruction valid
//   inst        - head instruction word (NOP when not valid)
//   inst_pc     - head byte PC (0 when not valid)
//   inst_ready  - decode consumes the head this cycle
// -----------------------------------------------------------------------------
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int          IMEM_AW  = IMEM_AW_DEF,
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_data,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    input  logic               halt,
    output logic               inst_valid,
    output logic [31:0]        inst,
    output logic [31:0]        inst_pc,
    input  logic               inst_ready
);

    logic [31:0] r_fpc;
    logic        w_pop;
    logic        w_push;
    logic        w_valid;
    logic [1:0]  w_count;
    fq_entry_t   w_head;
    fq_entry_t   w_push_entry;
    logic        w_unused_ok;

    // Redirect targets are word aligned; the dropped bits carry no meaning.
    assign w_unused_ok = &{1'b1, redirect_pc[1:0]};

    assign w_pop  = w_valid && inst_ready;
    // Halt and redirect both block the push; a pop frees a slot in the same
    // cycle so a full queue still streams one instruction per clock.
    assign w_push = !redirect && !halt && ((w_count != 2'd2) || w_pop);

    assign w_push_entry.pc   = r_fpc;
    assign w_push_entry.word = imem_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fpc <= RESET_PC;
        end else if (redirect) begin
            r_fpc <= {redirect_pc[31:2], 2'b00};
        end else if (w_push) begin
            r_fpc <= r_fpc + 32'd4;
        end
    end

    assign imem_addr = r_fpc[IMEM_AW+1:2];

    fetch_queue u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_entry (w_push_entry),
        .i_pop   (w_pop),
        .i_flush (redirect),
        .o_head  (w_head),
        .o_valid (w_valid),
        .o_count (w_count)
    );

    always_comb begin
        inst_valid = w_valid;
        inst       = NOP_INST;
        inst_pc    = '0;
        if (w_valid) begin
            inst    = w_head.word;
            inst_pc = w_head.pc;
        end
    end

endmodule
